// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder: word-addressed data memory with a configurable latency,   |
// | one outstanding transaction. Revision: 1.0                                 |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0]        C_CNT_INIT = 4'(LATENCY - 1);
  localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [3:0]        r_cnt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_op_we;
  logic [ADDR_W-1:0] w_op_addr;
  logic [DATA_W-1:0] w_op_wdata;
  logic [3:0]        w_op_be;
  logic              w_in_range;

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // With single-cycle latency the operation executes on the accept edge itself,
  // so the live request fields are used instead of the captured copy.
  assign w_op_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_op_be    = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_in_range = ({1'b0, w_op_addr} < C_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= C_CNT_INIT;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Gated by rst_n so a store whose commit edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_op_we && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (w_op_be[i]) begin
          r_mem[w_op_addr][8*i +: 8] <= w_op_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      if (!w_in_range) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else if (w_op_we) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end else begin
        r_rdata <= r_mem[w_op_addr];
        r_err   <= 1'b0;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_responder: scoreboard bench over four latency/depth configurations |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int NI = 4;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 15;
      default: return 4;
    endcase
  endfunction

  function automatic int depth_of(input int i);
    return (i == 1) ? 100 : 128;
  endfunction

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_we;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;

  logic        req_valid_v  [NI];
  logic        req_ready_v  [NI];
  logic        resp_valid_v [NI];
  logic [31:0] resp_rdata_v [NI];
  logic        resp_err_v   [NI];

  int          cur;
  logic        cur_req_ready, cur_resp_valid, cur_resp_err;
  logic [31:0] cur_resp_rdata;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;
  bit   seen = 0;
  exp_t held;
  exp_t mon_e;
  exp_t exp_q [$];

  logic [31:0] ref_mem [NI][128];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W (7),
      .DATA_W (32),
      .DEPTH  (depth_of(g)),
      .LATENCY(lat_of(g))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid_v[g]),
      .req_ready (req_ready_v[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .resp_valid(resp_valid_v[g]),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata_v[g]),
      .resp_err  (resp_err_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cur_req_ready  = req_ready_v[cur];
    cur_resp_valid = resp_valid_v[cur];
    cur_resp_rdata = resp_rdata_v[cur];
    cur_resp_err   = resp_err_v[cur];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d: got %h expected %h", name, cur, act, exp);
    end
  endtask

  // Reference: memory as a plain array, applied from the access rules.
  function automatic exp_t model(input int inst, input logic we, input logic [6:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.err   = 1'b0;
    e.rdata = 32'h0;
    if (int'(addr) >= depth_of(inst)) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ref_mem[inst][addr][8*i +: 8] = wdata[8*i +: 8];
      end
    end else begin
      e.rdata = ref_mem[inst][addr];
    end
    return e;
  endfunction

  // Monitor: pops on the first cycle of each response, then checks it holds.
  always @(negedge clk) begin
    if (mon_en && cur_resp_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp inst=%0d: got rdata=%h err=%b expected no response",
                   cur, cur_resp_rdata, cur_resp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_rdata", cur_resp_rdata, mon_e.rdata);
          check("resp_err", 32'(cur_resp_err), 32'(mon_e.err));
        end
        held.rdata = cur_resp_rdata;
        held.err   = cur_resp_err;
        seen = 1;
      end else begin
        check("stable_rdata", cur_resp_rdata, held.rdata);
        check("stable_err", 32'(cur_resp_err), 32'(held.err));
      end
      if (resp_ready) seen = 0;
    end
  end

  task automatic check_reset_all();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (req_ready_v[i] !== 1'b1 || resp_valid_v[i] !== 1'b0 ||
          resp_rdata_v[i] !== 32'h0 || resp_err_v[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state inst=%0d: got rdy=%b vld=%b rdata=%h err=%b expected 1 0 0 0",
                 i, req_ready_v[i], resp_valid_v[i], resp_rdata_v[i], resp_err_v[i]);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic do_txn(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input bit chain);
    logic rdy;
    int   n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid_v[cur] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = cur_req_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("accept_timeout", 32'(n), 32'(0));
    #1;
    req_valid_v[cur] = 1'b0;
    exp_q.push_back(model(cur, we, addr, wdata, be));
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (cur_resp_valid) break;
      check("req_ready_wait", 32'(cur_req_ready), 32'(0));
      if (n >= 40) break;
    end
    check("latency", 32'(n), 32'(lat_of(cur)));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (chain && h == 1) begin
        req_we    = 1'b0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        req_valid_v[cur] = 1'b1;
      end
      @(negedge clk);
      check("req_ready_resp", 32'(cur_req_ready), 32'(0));
      check("resp_valid_hold", 32'(cur_resp_valid), 32'(1));
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid_after_hs", 32'(cur_resp_valid), 32'(0));
    check("req_ready_after_hs", 32'(cur_req_ready), 32'(1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    resp_ready = 1'b0;
    cur = 0;
    for (int i = 0; i < NI; i++) req_valid_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_all();
    rst_n = 1'b1;
    mon_en = 1;

    for (int i = 0; i < NI; i++) begin
      cur = i;
      for (int a = 0; a < depth_of(i); a++) do_txn(1'b1, 7'(a), $urandom, 4'hF, 0, 0);
    end

    // Full-word store, byte-lane merge, empty-mask store, backpressure with RAW.
    cur = 0;
    do_txn(1'b1, 7'd5, 32'hDEADBEEF, 4'hF, 0, 0);
    do_txn(1'b0, 7'd5, 32'h0, 4'h0, 0, 0);
    do_txn(1'b1, 7'd5, 32'h11223344, 4'b0101, 0, 0);
    do_txn(1'b0, 7'd5, 32'h0, 4'h0, 0, 0);
    do_txn(1'b1, 7'd5, 32'hFFFFFFFF, 4'h0, 1, 0);
    do_txn(1'b0, 7'd5, 32'h0, 4'h0, 4, 1);
    do_txn(1'b0, 7'd5, 32'h0, 4'h0, 0, 0);
    do_txn(1'b1, 7'd127, 32'hA5A55A5A, 4'hF, 0, 0);
    do_txn(1'b0, 7'd127, 32'h0, 4'h0, 2, 0);

    cur = 1;
    do_txn(1'b0, 7'd99, 32'h0, 4'h0, 0, 0);
    do_txn(1'b1, 7'd100, 32'h12345678, 4'hF, 0, 0);
    do_txn(1'b0, 7'd99, 32'h0, 4'h0, 0, 0);
    do_txn(1'b1, 7'd127, 32'h87654321, 4'hF, 3, 0);
    do_txn(1'b0, 7'd100, 32'h0, 4'h0, 0, 0);

    cur = 2;
    do_txn(1'b1, 7'd10, 32'h0BADC0DE, 4'b1100, 2, 0);
    do_txn(1'b0, 7'd10, 32'h0, 4'h0, 0, 0);

    // Reset during the second WAIT cycle abandons the store.
    cur = 3;
    req_we = 1'b1;
    req_addr = 7'd3;
    req_wdata = 32'hCAFEF00D;
    req_be = 4'hF;
    req_valid_v[3] = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(cur_req_ready), 32'(1));
    @(posedge clk);
    #1;
    req_valid_v[3] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_all();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("mid_rst_no_resp", 32'(cur_resp_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    do_txn(1'b0, 7'd3, 32'h0, 4'h0, 0, 0);

    for (int i = 0; i < NI; i++) begin
      cur = i;
      for (int k = 0; k < 25; k++) begin
        do_txn(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 3), 0);
      end
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
